// File: rtl/brick_draw.sv
// brick_draw
//   Captures one brick record on a single-cycle start, writes the brick's
//   health into the brick-table RAM, then rasterises a BRICK_W x BRICK_H
//   rectangle into the VGA adapter one pixel per clock, row-major, with the
//   colour taken from the latched health. Pulses done once the last pixel
//   has been plotted.
//
//   Optional feature macro: BRICK_BORDER_EN
//     defined   -> edge pixels of a live brick (health != 0) are drawn white
//     undefined -> every pixel uses the health colour map
//
// Ports
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   draw request, honoured only in IDLE
//   x_in        in   [9:0] brick origin x (top-left pixel)
//   y_in        in   [9:0] brick origin y
//   address_in  in   [9:0] brick-table index
//   health_in   in   [1:0] brick health (0 = destroyed/empty)
//   busy        out  high whenever not IDLE
//   done        out  one-cycle completion pulse
//   vga_x       out  [9:0] pixel x (base + col, wraps mod 1024)
//   vga_y       out  [9:0] pixel y (base + row, wraps mod 1024)
//   colour      out  [2:0] pixel colour {R,G,B}
//   plot        out  VGA write enable
//   mem_addr    out  [9:0] brick-table RAM address
//   mem_data    out  [1:0] brick-table RAM write data
//   mem_we      out  brick-table RAM write enable
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; record latched on the accepting edge
// MEMWR | one cycle: health written to brick table at latched addr
// DRAW  | one pixel per cycle, col fastest, BRICK_W*BRICK_H cycles
// DONE  | one cycle: done pulse, then back to IDLE

module brick_draw #(
    parameter int BRICK_W = 16,
    parameter int BRICK_H = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic [9:0] address_in,
    input  logic [1:0] health_in,
    output logic       busy,
    output logic       done,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [9:0] mem_addr,
    output logic [1:0] mem_data,
    output logic       mem_we
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MEMWR = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Counters are sized for the largest legal brick (64 pixels per side).
    localparam logic [5:0] COL_LAST = 6'(BRICK_W - 1);
    localparam logic [5:0] ROW_LAST = 6'(BRICK_H - 1);

    logic [1:0] state;
    logic [9:0] x_base;
    logic [9:0] y_base;
    logic [9:0] addr_lat;
    logic [1:0] health_lat;
    logic [5:0] col;
    logic [5:0] row;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            x_base     <= '0;
            y_base     <= '0;
            addr_lat   <= '0;
            health_lat <= '0;
            col        <= '0;
            row        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_base     <= x_in;
                        y_base     <= y_in;
                        addr_lat   <= address_in;
                        health_lat <= health_in;
                        col        <= '0;
                        row        <= '0;
                        state      <= S_MEMWR;
                    end
                end
                S_MEMWR: begin
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 6'd1;
                        if (row == ROW_LAST) begin
                            state <= S_DONE;
                        end
                    end else begin
                        col <= col + 6'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only; no input reaches an output
    // combinationally.
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign plot     = (state == S_DRAW);
    assign mem_we   = (state == S_MEMWR);
    assign mem_addr = addr_lat;
    assign mem_data = health_lat;
    assign vga_x    = x_base + {4'd0, col};
    assign vga_y    = y_base + {4'd0, row};

    logic [2:0] health_colour;

    always_comb begin
        health_colour = 3'b000;
        case (health_lat)
            2'd0:    health_colour = 3'b000;
            2'd1:    health_colour = 3'b100;
            2'd2:    health_colour = 3'b110;
            default: health_colour = 3'b010;
        endcase
    end

`ifdef BRICK_BORDER_EN
    logic on_edge;

    assign on_edge = (col == 6'd0) || (col == COL_LAST) ||
                     (row == 6'd0) || (row == ROW_LAST);

    // An empty brick must erase fully, so the white frame is suppressed
    // when health is 0.
    always_comb begin
        colour = health_colour;
        if (on_edge && (health_lat != 2'd0)) begin
            colour = 3'b111;
        end
    end
`else
    always_comb begin
        colour = health_colour;
    end
`endif

endmodule

// File: tb/tb_brick_draw.sv
module tb_brick_draw;

    localparam int W = 16;
    localparam int H = 8;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic [9:0] address_in;
    logic [1:0] health_in;
    logic       busy;
    logic       done;
    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic [9:0] mem_addr;
    logic [1:0] mem_data;
    logic       mem_we;

    int errors = 0;
    int checks = 0;

    logic [22:0] px_q[$];
    logic [11:0] mem_q[$];

    int mem_ks[$];
    int done_ks[$];
    int plot_cnt;
    int busy_cnt;

    brick_draw #(.BRICK_W(W), .BRICK_H(H)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_in(x_in), .y_in(y_in), .address_in(address_in), .health_in(health_in),
        .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .colour(colour), .plot(plot), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_colour(input logic [1:0] h, input int c, input int r);
        logic [2:0] v;
        case (h)
            2'd0:    v = 3'b000;
            2'd1:    v = 3'b100;
            2'd2:    v = 3'b110;
            default: v = 3'b010;
        endcase
`ifdef BRICK_BORDER_EN
        if (h != 2'd0 && (c == 0 || c == W - 1 || r == 0 || r == H - 1)) v = 3'b111;
`endif
        return v;
    endfunction

    // Reference model: expected pixels in row-major order plus the RAM write.
    task automatic push_brick(input int x, input int y, input int a, input logic [1:0] h);
        logic [9:0] ex;
        logic [9:0] ey;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                ex = 10'((x + c) % 1024);
                ey = 10'((y + r) % 1024);
                px_q.push_back({ex, ey, exp_colour(h, c, r)});
            end
        end
        mem_q.push_back({10'(a), h});
    endtask

    // Scoreboard: every plot / RAM write the DUT produces is compared with
    // the next expected entry.
    always @(negedge clk) begin
        logic [22:0] ep;
        logic [11:0] em;
        if (plot === 1'b1) begin
            checks++;
            if (px_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_extra: got x=%0d y=%0d c=%b, none expected", vga_x, vga_y, colour);
            end else begin
                ep = px_q.pop_front();
                if ({vga_x, vga_y, colour} !== ep) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                             vga_x, vga_y, colour, ep[22:13], ep[12:3], ep[2:0]);
                end
            end
        end
        if (mem_we === 1'b1) begin
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL memwr_extra: got addr=%0d data=%0d, none expected", mem_addr, mem_data);
            end else begin
                em = mem_q.pop_front();
                if ({mem_addr, mem_data} !== em) begin
                    errors++;
                    $display("FAIL memwr: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             mem_addr, mem_data, em[11:2], em[1:0]);
                end
            end
        end
    end

    task automatic clear_obs();
        mem_ks.delete();
        done_ks.delete();
        plot_cnt = 0;
        busy_cnt = 0;
    endtask

    // Drive start for one sampling edge (edge 0 is the next rising edge).
    task automatic pulse_start(input int x, input int y, input int a, input logic [1:0] h);
        @(negedge clk);
        x_in = 10'(x);
        y_in = 10'(y);
        address_in = 10'(a);
        health_in = h;
        start = 1'b1;
    endtask

    // Observe cycles k0 .. k0+n-1; k is the count of rising edges after edge 0.
    task automatic watch(input int k0, input int n, input int off_k);
        for (int k = k0; k < k0 + n; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1) mem_ks.push_back(k);
            if (done === 1'b1) done_ks.push_back(k);
            if (plot === 1'b1) plot_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (k == off_k) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        x_in = '0; y_in = '0; address_in = '0; health_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, plot, mem_we, vga_x, vga_y, mem_addr, mem_data, colour} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b plot=%b we=%b x=%0d y=%0d a=%0d d=%0d c=%b, expected all 0",
                     busy, done, plot, mem_we, vga_x, vga_y, mem_addr, mem_data, colour);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, plot, mem_we, vga_x, vga_y, mem_addr, mem_data, colour} !== '0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: got busy=%b done=%b plot=%b we=%b x=%0d y=%0d, expected all 0",
                         i, busy, done, plot, mem_we, vga_x, vga_y);
            end
        end
    endtask

    task automatic test_single();
        clear_obs();
        push_brick(40, 20, 5, 2'd3);
        pulse_start(40, 20, 5, 2'd3);
        watch(0, 140, 0);
        checks++;
        if (mem_ks.size() != 1 || mem_ks[0] != 0) begin
            errors++;
            $display("FAIL single_memwr_cycle: got %0d writes first k=%0d, expected 1 at k=0",
                     mem_ks.size(), mem_ks.size() ? mem_ks[0] : -1);
        end
        checks++;
        if (done_ks.size() != 1 || done_ks[0] != 129) begin
            errors++;
            $display("FAIL single_done_cycle: got %0d pulses first k=%0d, expected 1 at k=129",
                     done_ks.size(), done_ks.size() ? done_ks[0] : -1);
        end
        checks++;
        if (plot_cnt != W * H) begin
            errors++;
            $display("FAIL single_plot_count: got %0d, expected %0d", plot_cnt, W * H);
        end
        checks++;
        if (busy_cnt != W * H + 2) begin
            errors++;
            $display("FAIL single_busy_cycles: got %0d, expected %0d", busy_cnt, W * H + 2);
        end
        checks++;
        if (px_q.size() != 0) begin
            errors++;
            $display("FAIL single_pixels_left: got %0d unplotted, expected 0", px_q.size());
        end
    endtask

    task automatic test_erase();
        clear_obs();
        push_brick(0, 0, 12, 2'd0);
        pulse_start(0, 0, 12, 2'd0);
        watch(0, 135, 0);
        checks++;
        if (plot_cnt != W * H || px_q.size() != 0 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL erase_count: got plots=%0d left=%0d memleft=%0d, expected %0d 0 0",
                     plot_cnt, px_q.size(), mem_q.size(), W * H);
        end
    endtask

    task automatic test_wrap();
        clear_obs();
        push_brick(1020, 1020, 1023, 2'd2);
        pulse_start(1020, 1020, 1023, 2'd2);
        watch(0, 135, 0);
        checks++;
        if (plot_cnt != W * H || px_q.size() != 0 || done_ks.size() != 1) begin
            errors++;
            $display("FAIL wrap_count: got plots=%0d left=%0d dones=%0d, expected %0d 0 1",
                     plot_cnt, px_q.size(), done_ks.size(), W * H);
        end
    endtask

    task automatic test_busy_ignore();
        clear_obs();
        push_brick(300, 200, 33, 2'd1);
        pulse_start(300, 200, 33, 2'd1);
        watch(0, 10, 0);
        x_in = 10'd7; y_in = 10'd9; address_in = 10'd99; health_in = 2'd3;
        start = 1'b1;
        watch(10, 130, 10);
        checks++;
        if (mem_ks.size() != 1 || done_ks.size() != 1 || done_ks[0] != 129) begin
            errors++;
            $display("FAIL ignore_timing: got writes=%0d dones=%0d first done k=%0d, expected 1 1 129",
                     mem_ks.size(), done_ks.size(), done_ks.size() ? done_ks[0] : -1);
        end
        checks++;
        if (plot_cnt != W * H || px_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_plots: got plots=%0d left=%0d, expected %0d 0", plot_cnt, px_q.size(), W * H);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        push_brick(500, 100, 40, 2'd3);
        push_brick(520, 110, 41, 2'd1);
        pulse_start(500, 100, 40, 2'd3);
        watch(0, 1, -1);
        x_in = 10'd520; y_in = 10'd110; address_in = 10'd41; health_in = 2'd1;
        watch(1, 131, 131);
        watch(132, 135, -1);
        checks++;
        if (mem_ks.size() != 2 || mem_ks[0] != 0 || mem_ks[1] != W * H + 3) begin
            errors++;
            $display("FAIL b2b_memwr: got %0d writes k1=%0d, expected 2 with k1=%0d",
                     mem_ks.size(), mem_ks.size() > 1 ? mem_ks[1] : -1, W * H + 3);
        end
        checks++;
        if (done_ks.size() != 2 || done_ks[0] != 129 || done_ks[1] != 260) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses k1=%0d, expected 2 at 129 and 260",
                     done_ks.size(), done_ks.size() > 1 ? done_ks[1] : -1);
        end
        checks++;
        if (plot_cnt != 2 * W * H || px_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_plots: got plots=%0d left=%0d, expected %0d 0", plot_cnt, px_q.size(), 2 * W * H);
        end
    endtask

    task automatic test_mid_reset();
        clear_obs();
        push_brick(100, 50, 7, 2'd1);
        pulse_start(100, 50, 7, 2'd1);
        watch(0, 59, 0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: got plot=%b busy=%b, expected 0 0", plot, busy);
        end
        px_q.delete();
        mem_q.delete();
        clear_obs();
        watch(59, 5, -1);
        @(negedge clk);
        resetn = 1'b1;
        watch(64, 80, -1);
        checks++;
        if (done_ks.size() != 0 || plot_cnt != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got dones=%0d plots=%0d busy=%0d, expected 0 0 0",
                     done_ks.size(), plot_cnt, busy_cnt);
        end
        clear_obs();
        push_brick(200, 300, 8, 2'd2);
        pulse_start(200, 300, 8, 2'd2);
        watch(0, 135, 0);
        checks++;
        if (plot_cnt != W * H || px_q.size() != 0 || done_ks.size() != 1 || done_ks[0] != 129) begin
            errors++;
            $display("FAIL midreset_redraw: got plots=%0d left=%0d dones=%0d, expected %0d 0 1 at 129",
                     plot_cnt, px_q.size(), done_ks.size(), W * H);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_erase();
        test_wrap();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
